framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
// Read side of the framebuffer SRAM: walks VGA raster timing, issues read addresses to one
// SRAM port (1-clk registered read), realigns returned data with the syncs and drives pixels.
// Framebuffer is FB_W x FB_H, upscaled by 2**SCALE_SHIFT in both axes. The CPU writes the
// other port; this block never writes.
// PARAMETERS
// D_WIDTH     8    pixel/SRAM word width
// A_WIDTH     15   SRAM address width; FB_W*FB_H <= 2**A_WIDTH
// FB_W        160  framebuffer width in words
// SCALE_SHIFT 2    log2 upscale factor (160x120 -> 640x480)
// CLK_DIV     2    clk cycles per pixel (>=1); 50 MHz -> 25 MHz pixel
// H_ACT,H_FP,H_SYNC,H_BP  640,16,96,48   horizontal timing, pixels
// V_ACT,V_FP,V_SYNC,V_BP  480,10,2,33    vertical timing, lines
// SYNC_POL    0    sync active level (0 = active-low)
// PORTS
// clk          in   1        system clock
// rst_n        in   1        synchronous reset, active low
// read_addr    out  A_WIDTH  SRAM read address (combinational from addr counter)
// read_data    in   D_WIDTH  SRAM read data, valid 1 clk after read_addr
// pixel        out  D_WIDTH  registered pixel; 0 outside active area
// hsync        out  1        registered, aligned with pixel
// vsync        out  1        registered, aligned with pixel
// frame_start  out  1        1-clk pulse when raster enters (0,0)
// in_vblank    out  1        level, 1 while v >= V_ACT (CPU safe-write window)
// BEHAVIOUR
// - Reset: h=v=0, div=0, addr=row_base=0, pixel=0, hsync=vsync=!SYNC_POL, frame_start=0,
//   in_vblank=0. Reset mid-frame restarts raster at (0,0) next cycle, no partial state kept.
// - div counts 0..CLK_DIV-1; pix_en=(div==CLK_DIV-1). h/v advance only on pix_en.
// - h wraps at H_ACT+H_FP+H_SYNC+H_BP-1 -> 0 and v increments; v wraps at total-1 -> 0.
// - active = h<H_ACT && v<V_ACT. hsync active for H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC;
//   vsync likewise on v.
// - Address: no multiplier. On pix_en in active region, if h[SCALE_SHIFT-1:0]==all-ones
//   addr++. At h wrap: if v[SCALE_SHIFT-1:0]==all-ones, row_base+=FB_W and addr=row_base+FB_W,
//   else addr=row_base. At v wrap: addr=row_base=0. Blanking: addr held.
// - Pipeline: stage0 = h/v/addr (drive read_addr); stage1 = SRAM register + 1-clk delay of
//   active/hsync/vsync/pix_en; stage2 = output regs load on delayed pix_en:
//   pixel=active_d?read_data:0, hsync/vsync from delayed copies. Total 2 clk, constant for
//   every CLK_DIV, so syncs and pixels never skew.
// - frame_start pulses the clk of pix_en taking (h,v) to (0,0); not after reset release.
// - in_vblank registered from stage0 v; independent of output pipeline.
// - Widths: h,v sized $clog2(total); addr/row_base A_WIDTH, no wrap in normal operation
//   (last word FB_W*FB_H-1).
// STRUCTURE
// - vga_timing_pkg: timing localparams/defaults, totals, sync start/end, typedef raster_pos_t {h,v}.
// - Sub-module vga_timing_gen: div, h/v counters, pix_en, active/hsync/vsync/frame_start.
//   Top keeps address generator and 2-stage alignment pipeline.
// TESTING
// - Reset 5 clk, release -> pixel=0, hsync=vsync=1, frame_start=0; read_addr=0.
// - SRAM model returns data=addr[7:0]; line 0 -> pixel 0 for 4 pixels (8 clk), then 1,... 159.
// - Lines 0-3 start at addr 0; line 4 starts at 160; line 479 ends at 19199.
// - hsync low 96*CLK_DIV=192 clk starting 656 pixels after line start; vsync low 2 lines.
// - Blanking: pixel stays 0 while SRAM returns 0xFF; in_vblank=1 for lines 480..524.
// - Frame wrap: frame_start single pulse, next read_addr=0; assert rst_n low at line 200 ->
//   after release addr restarts at 0 and line 0 data reproduced.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Raster timing defaults and shared types for the framebuffer scanout path.
// Modules take their geometry as parameters that default to these values.
package vga_timing_pkg;

    localparam int D_WIDTH_DEF     = 8;
    localparam int A_WIDTH_DEF     = 15;
    localparam int FB_W_DEF        = 160;
    localparam int SCALE_SHIFT_DEF = 2;
    localparam int CLK_DIV_DEF     = 2;

    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    // Raster position as seen outside the timing generator; counters are
    // narrower internally and zero-extended into these fields.
    localparam int POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] h;
        logic [POS_W-1:0] v;
    } raster_pos_t;

    function automatic int total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider and h/v raster counters with their combinational decodes
// (active window, syncs) plus a registered frame_start pulse.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACT    = H_ACT_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACT    = V_ACT_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output raster_pos_t pos,
    output logic        pix_en,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_C  = H_W'(H_ACT);
    localparam logic [H_W-1:0]   HS_START = H_W'(H_ACT + H_FP);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_C  = V_W'(V_ACT);
    localparam logic [V_W-1:0]   VS_START = V_W'(V_ACT + V_FP);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACT + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             line_end;
    logic             frame_end;

    assign pix_en    = (div == DIV_LAST);
    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            div         <= pix_en ? '0 : div + 1'b1;
            if (pix_en) begin
                if (line_end) begin
                    h <= '0;
                    if (frame_end) begin
                        v           <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        v <= v + 1'b1;
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign pos.h  = POS_W'(h);
    assign pos.v  = POS_W'(v);
    assign active = (h < H_ACT_C) && (v < V_ACT_C);
    assign hsync  = ((h >= HS_START) && (h < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vsync  = ((v >= VS_START) && (v < VS_END)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read side: drives SRAM read addresses along the raster and
// realigns the 1-clk registered read data with the syncs on the output.
module framebuffer_scanout
    import vga_timing_pkg::*;
#(
    parameter int D_WIDTH     = D_WIDTH_DEF,
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int FB_W        = FB_W_DEF,
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int H_ACT       = H_ACT_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACT       = V_ACT_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [A_WIDTH-1:0] read_addr,
    input  logic [D_WIDTH-1:0] read_data,
    output logic [D_WIDTH-1:0] pixel,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               in_vblank
);

    localparam int H_TOTAL = total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACT, V_FP, V_SYNC, V_BP);

    localparam logic [POS_W-1:0]       H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]       V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]       V_ACT_P  = POS_W'(V_ACT);
    localparam logic [A_WIDTH-1:0]     ROW_STEP = A_WIDTH'(FB_W);
    localparam logic [SCALE_SHIFT-1:0] SUB_LAST = '1;

    raster_pos_t pos;
    logic        pix_en;
    logic        active;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        line_end;
    logic        frame_end;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACT   (H_ACT),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACT   (V_ACT),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .pos        (pos),
        .pix_en     (pix_en),
        .active     (active),
        .hsync      (hsync_raw),
        .vsync      (vsync_raw),
        .frame_start(frame_start)
    );

    assign line_end  = (pos.h == H_LAST);
    assign frame_end = line_end && (pos.v == V_LAST);

    // Address walk without a multiplier: each source row repeats for
    // 2**SCALE_SHIFT lines from row_base, and each word for 2**SCALE_SHIFT pixels.
    logic [A_WIDTH-1:0] addr;
    logic [A_WIDTH-1:0] row_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            row_base <= '0;
        end else if (pix_en) begin
            if (frame_end) begin
                addr     <= '0;
                row_base <= '0;
            end else if (line_end) begin
                if (pos.v[SCALE_SHIFT-1:0] == SUB_LAST) begin
                    row_base <= row_base + ROW_STEP;
                    addr     <= row_base + ROW_STEP;
                end else begin
                    addr <= row_base;
                end
            end else if (active && (pos.h[SCALE_SHIFT-1:0] == SUB_LAST)) begin
                addr <= addr + 1'b1;
            end
        end
    end

    assign read_addr = addr;

    // Stage 1 runs beside the SRAM's own output register; stage 2 loads on
    // the delayed pixel strobe so data and syncs leave together.
    logic active_d;
    logic hsync_d;
    logic vsync_d;
    logic pix_en_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_d  <= 1'b0;
            hsync_d   <= ~SYNC_POL;
            vsync_d   <= ~SYNC_POL;
            pix_en_d  <= 1'b0;
            pixel     <= '0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            in_vblank <= 1'b0;
        end else begin
            active_d  <= active;
            hsync_d   <= hsync_raw;
            vsync_d   <= vsync_raw;
            pix_en_d  <= pix_en;
            in_vblank <= (pos.v >= V_ACT_P);
            if (pix_en_d) begin
                pixel <= active_d ? read_data : '0;
                hsync <= hsync_d;
                vsync <= vsync_d;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: a full-size 640x480 instance and a small
// fast-wrapping instance, both checked every cycle against a raster model.
`timescale 1ns/1ps
module tb_framebuffer_scanout;

    typedef struct {
        int   ha, hf, hs, hb;
        int   va, vf, vs, vb;
        int   fbw, sh, cd;
        logic pol;
    } geom_t;

    geom_t ga, gb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;

    // ---------------- DUTs and SRAM models ----------------
    logic [14:0] ra_a;
    logic [7:0]  rd_a, px_a;
    logic        hs_a, vs_a, fs_a, vb_a;
    logic [7:0]  ra_b;
    logic [7:0]  rd_b, px_b;
    logic        hs_b, vs_b, fs_b, vb_b;

    logic [7:0] mem [0:32767];

    always @(posedge clk) begin
        rd_a <= mem[ra_a];
        rd_b <= mem[ra_b];
    end

    framebuffer_scanout dut_a (
        .clk(clk), .rst_n(rst_a_n), .read_addr(ra_a), .read_data(rd_a),
        .pixel(px_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .in_vblank(vb_a)
    );

    framebuffer_scanout #(
        .D_WIDTH(8), .A_WIDTH(8), .FB_W(16), .SCALE_SHIFT(1), .CLK_DIV(3),
        .H_ACT(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACT(16), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .read_addr(ra_b), .read_data(rd_b),
        .pixel(px_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .in_vblank(vb_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: cycle t since reset (t=0 is the reset state) maps to raster
    // pixel t/cd; outputs show the pixel whose strobe was two clocks earlier.
    function automatic void model(input geom_t g, input int t,
                                  output logic [7:0] e_px, output logic e_hs,
                                  output logic e_vs, output logic e_fs,
                                  output logic e_vb, output logic [31:0] e_ra,
                                  output logic ra_ok);
        int ht, vt, n, h, v, k;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        n  = t / g.cd;
        h  = n % ht;
        v  = (n / ht) % vt;
        ra_ok = (h < g.ha) && (v < g.va);
        e_ra  = 32'(((v >> g.sh) * g.fbw) + (h >> g.sh));
        e_fs  = (t > 0) && (t % g.cd == 0) && (n % (ht * vt) == 0);
        e_vb  = (t > 0) && (((((t - 1) / g.cd) / ht) % vt) >= g.va);
        k = t - 1 - g.cd;
        if (k < 0) begin
            e_px = 8'h00;
            e_hs = ~g.pol;
            e_vs = ~g.pol;
        end else begin
            n = k / g.cd;
            h = n % ht;
            v = (n / ht) % vt;
            e_px = ((h < g.ha) && (v < g.va)) ? mem[((v >> g.sh) * g.fbw) + (h >> g.sh)] : 8'h00;
            e_hs = ((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs)) ? g.pol : ~g.pol;
            e_vs = ((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs)) ? g.pol : ~g.pol;
        end
    endfunction

    task automatic check_inst(input string nm, input geom_t g, input int t,
                              input logic [31:0] ra, input logic [7:0] px,
                              input logic hs, input logic vs, input logic fs,
                              input logic vb);
        logic [7:0]  e_px;
        logic        e_hs, e_vs, e_fs, e_vb, ra_ok;
        logic [31:0] e_ra;
        model(g, t, e_px, e_hs, e_vs, e_fs, e_vb, e_ra, ra_ok);
        check({nm, "_pixel"}, 32'(px), 32'(e_px));
        check({nm, "_hsync"}, 32'(hs), 32'(e_hs));
        check({nm, "_vsync"}, 32'(vs), 32'(e_vs));
        check({nm, "_frame_start"}, 32'(fs), 32'(e_fs));
        check({nm, "_in_vblank"}, 32'(vb), 32'(e_vb));
        if (ra_ok) check({nm, "_read_addr"}, ra, e_ra);
    endtask

    // Cycle counters: -1 until the first reset edge, 0 while held in reset.
    int t_a = -1;
    int t_b = -1;

    always @(posedge clk) begin
        if (!rst_a_n) t_a = 0;
        else if (t_a >= 0) t_a = t_a + 1;
        if (!rst_b_n) t_b = 0;
        else if (t_b >= 0) t_b = t_b + 1;
    end

    always @(negedge clk) begin
        if (t_a >= 0) check_inst("a", ga, t_a, {17'd0, ra_a}, px_a, hs_a, vs_a, fs_a, vb_a);
        if (t_b >= 0) check_inst("b", gb, t_b, {24'd0, ra_b}, px_b, hs_b, vs_b, fs_b, vb_b);
    end

    // ---------------- driver ----------------
    task automatic pulse_reset_a(input int cycles);
        rst_a_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_a_n = 1'b1;
    endtask

    task automatic pulse_reset_b(input int cycles);
        rst_b_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_b_n = 1'b1;
    endtask

    initial begin
        ga = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
               fbw: 160, sh: 2, cd: 2, pol: 1'b0};
        gb = '{ha: 32, hf: 4, hs: 6, hb: 6, va: 16, vf: 2, vs: 2, vb: 4,
               fbw: 16, sh: 1, cd: 3, pol: 1'b1};
        // Unused words read back 0xFF so blanking gating is visible.
        for (int i = 0; i < 32768; i++) mem[i] = (i < 19200) ? 8'($urandom) : 8'hFF;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        fork
            begin
                // Full-size raster: past line 4, then a mid-line reset and restart.
                repeat (8000 + $urandom_range(0, 600)) @(posedge clk);
                #1 pulse_reset_a($urandom_range(2, 6));
                repeat (3600) @(posedge clk);
            end
            begin
                // Small raster: two frame wraps, a mid-frame reset, another wrap.
                repeat (2 * 3456 + $urandom_range(100, 3000)) @(posedge clk);
                #1 pulse_reset_b($urandom_range(2, 6));
                repeat (4000) @(posedge clk);
            end
        join

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
